gpio_in_capture: RTL and testbench

GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

---
 rtl/gpio_in_capture.sv | 74 +++++++
 tb/tb_gpio_in_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: synchronized, debounced 8-bit GPIO input capture with edge status registers and irq
module gpio_in_capture #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gpio_in,
  input  logic [3:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       re,
  output logic [7:0] rdata_out,
  output logic       irq
);
  localparam logic [3:0] DB = 4'(DB_CYCLES);
  logic [7:0]      sync1_q, sync2_q, level_q, level_d, level_dly_q;
  logic [7:0]      rise_q, rise_d, fall_q, fall_d;
  logic [7:0]      rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [7:0]      rdata_q, rdata_d, rd_val;
  logic [7:0][3:0] cnt_q, cnt_d;
  logic            irq_q, irq_d;
  // per-bit debounce: count mismatching cycles, adopt the synced value on the DB_CYCLES-th one
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i]   = (sync2_q[i] != level_q[i] && cnt_q[i] + 4'd1 != DB) ? cnt_q[i] + 4'd1 : 4'd0;
      level_d[i] = (sync2_q[i] != level_q[i] && cnt_q[i] + 4'd1 == DB) ? sync2_q[i] : level_q[i];
    end
  end
  // register file: W1C status where a new event beats a clear, RW enables, registered read and irq
  always_comb begin
    rise_d    = (rise_q & ~((we && addr == 4'h1) ? wdata : 8'h00)) | (level_q & ~level_dly_q);
    fall_d    = (fall_q & ~((we && addr == 4'h2) ? wdata : 8'h00)) | (level_dly_q & ~level_q);
    rise_en_d = (we && addr == 4'h3) ? wdata : rise_en_q;
    fall_en_d = (we && addr == 4'h4) ? wdata : fall_en_q;
    rd_val    = addr == 4'h0 ? level_q :
                addr == 4'h1 ? rise_q :
                addr == 4'h2 ? fall_q :
                addr == 4'h3 ? rise_en_q :
                addr == 4'h4 ? fall_en_q :
                addr == 4'h5 ? sync2_q : 8'h00;
    rdata_d   = re ? rd_val : rdata_q;
    irq_d     = |((rise_q & rise_en_q) | (fall_q & fall_en_q));
  end
  // state registers, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end
  assign rdata_out = rdata_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_gpio_in_capture.sv
// tb_gpio_in_capture: directed scenarios plus randomized run against a sample-window reference model
module tb_gpio_in_capture;
  localparam int DB = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gpio_in = '0;
  logic [3:0] addr = '0;
  logic       we = 1'b0;
  logic [7:0] wdata = '0;
  logic       re = 1'b0;
  logic [7:0] rdata_out;
  logic       irq;
  int tests = 0;
  int fails = 0;

  gpio_in_capture #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .addr(addr), .we(we),
    .wdata(wdata), .re(re), .rdata_out(rdata_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // reference model: a pin level is accepted once the last DB synchronized samples all disagree with it
  logic [7:0] hist [0:17] = '{default: 8'h00};
  logic [7:0] lvl_m = '0, rise_m = '0, fall_m = '0, ren_m = '0, fen_m = '0, rd_m = '0;
  logic [7:0] rp_m = '0, fp_m = '0, all1, all0, nl, rv;
  logic       irq_m = 1'b0;

  always_comb begin
    all1 = 8'hFF;
    all0 = 8'hFF;
    for (int k = 1; k <= DB; k++) begin
      all1 &= hist[k];
      all0 &= ~hist[k];
    end
    nl = (lvl_m | all1) & ~all0;
    rv = addr == 4'h0 ? lvl_m : addr == 4'h1 ? rise_m : addr == 4'h2 ? fall_m :
         addr == 4'h3 ? ren_m : addr == 4'h4 ? fen_m : addr == 4'h5 ? hist[1] : 8'h00;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 18; k++) hist[k] <= 8'h00;
      lvl_m <= '0; rise_m <= '0; fall_m <= '0; ren_m <= '0; fen_m <= '0;
      rd_m <= '0; rp_m <= '0; fp_m <= '0; irq_m <= 1'b0;
    end else begin
      hist[0] <= gpio_in;
      for (int k = 1; k < 18; k++) hist[k] <= hist[k-1];
      rp_m   <= nl & ~lvl_m;
      fp_m   <= lvl_m & ~nl;
      lvl_m  <= nl;
      rise_m <= (rise_m & ~((we && addr == 4'h1) ? wdata : 8'h00)) | rp_m;
      fall_m <= (fall_m & ~((we && addr == 4'h2) ? wdata : 8'h00)) | fp_m;
      if (we && addr == 4'h3) ren_m <= wdata;
      if (we && addr == 4'h4) fen_m <= wdata;
      if (re) rd_m <= rv;
      irq_m  <= |((rise_m & ren_m) | (fall_m & fen_m));
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1; re = 1'b0;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; re = 1'b1; we = 1'b0;
    @(negedge clk);
    re = 1'b0;
    d = rdata_out;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic [3:0] as [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9};
    #2 rst = 1'b0;
    #1;
    tests++;
    if (rdata_out !== 8'h00 || irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: rdata_out=%h irq=%b, required 00 and 0", rdata_out, irq);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    foreach (as[j]) begin
      rd(as[j], d);
      tests++;
      if (d !== 8'h00) begin
        fails++;
        $display("FAIL reset_reg_%0h: read %h, required 00", as[j], d);
      end
    end
  endtask

  task automatic test_rise_latency;
    logic [7:0] d;
    @(negedge clk);
    gpio_in = 8'h01; addr = 4'h1; re = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (n == 7) begin
        tests++;
        if (rdata_out !== 8'h00) begin
          fails++;
          $display("FAIL rise_not_early: RISE at cycle 6 read %h, required 00", rdata_out);
        end
      end
      if (n == 8) begin
        tests++;
        if (rdata_out !== 8'h01) begin
          fails++;
          $display("FAIL rise_at_7: RISE at cycle 7 read %h, required 01", rdata_out);
        end
      end
    end
    @(negedge clk);
    re = 1'b0;
    rd(4'h0, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL rise_level: LEVEL %h, required 01", d); end
    rd(4'h2, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL rise_fall: FALL %h, required 00", d); end
  endtask

  task automatic test_glitch;
    logic [7:0] d;
    logic [7:0] raw_or = 8'h00;
    @(negedge clk);
    gpio_in = 8'h09; addr = 4'h5; re = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 3) gpio_in = 8'h01;
      raw_or |= rdata_out;
    end
    re = 1'b0;
    tests++;
    if (raw_or !== 8'h09) begin fails++; $display("FAIL glitch_raw: RAW union %h, required 09", raw_or); end
    rd(4'h0, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL glitch_level: LEVEL %h, required 01", d); end
    rd(4'h1, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL glitch_rise: RISE %h, required 01", d); end
    rd(4'h2, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL glitch_fall: FALL %h, required 00", d); end
  endtask

  task automatic test_irq_w1c;
    logic [7:0] d;
    @(negedge clk);
    gpio_in = 8'h05;
    repeat (10) @(negedge clk);
    rd(4'h1, d);
    tests++;
    if (d !== 8'h05) begin fails++; $display("FAIL irq_rise_pre: RISE %h, required 05", d); end
    wr(4'h3, 8'h04);
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_lag: irq %b right after enable, required 0", irq); end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_enable: irq %b, required 1", irq); end
    addr = 4'h1; wdata = 8'h04; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    tests++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_w1c_lag: irq %b, required 1", irq); end
    @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_w1c_drop: irq %b, required 0", irq); end
    rd(4'h1, d);
    tests++;
    if (d !== 8'h01) begin fails++; $display("FAIL irq_w1c_rise: RISE %h, required 01", d); end
  endtask

  task automatic test_set_beats_clear;
    logic [7:0] d;
    @(negedge clk);
    gpio_in = 8'h01;
    repeat (10) @(negedge clk);
    gpio_in = 8'h05;
    repeat (6) @(negedge clk);
    addr = 4'h1; wdata = 8'h04; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    rd(4'h1, d);
    tests++;
    if (d !== 8'h05) begin fails++; $display("FAIL set_beats_clear: RISE %h, required 05", d); end
    rd(4'h2, d);
    tests++;
    if (d !== 8'h04) begin fails++; $display("FAIL set_beats_clear_fall: FALL %h, required 04", d); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    wr(4'h3, 8'h00);
    @(negedge clk);
    addr = 4'h3; wdata = 8'hA5; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    tests++;
    if (rdata_out !== 8'h00) begin fails++; $display("FAIL rw_same_pre: rdata %h, required 00", rdata_out); end
    rd(4'h3, d);
    tests++;
    if (d !== 8'hA5) begin fails++; $display("FAIL rw_same_post: RISE_EN %h, required a5", d); end
    wr(4'h0, 8'hFF);
    rd(4'h0, d);
    tests++;
    if (d !== 8'h05) begin fails++; $display("FAIL ro_level: LEVEL %h, required 05", d); end
    wr(4'h5, 8'h00);
    rd(4'h5, d);
    tests++;
    if (d !== 8'h05) begin fails++; $display("FAIL ro_raw: RAW %h, required 05", d); end
    wr(4'h9, 8'hFF);
    rd(4'h9, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL unmapped: read %h, required 00", d); end
  endtask

  task automatic test_async_reset;
    logic [7:0] d;
    wr(4'h3, 8'hFF);
    rd(4'h0, d);
    tests++;
    if (d !== 8'h05 || irq !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: LEVEL %h irq %b, required 05 and 1", d, irq);
    end
    @(negedge clk);
    gpio_in = 8'h85;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (irq !== 1'b0 || rdata_out !== 8'h00) begin
      fails++;
      $display("FAIL async_reset: irq %b rdata %h, required 0 and 00", irq, rdata_out);
    end
    @(negedge clk);
    rst = 1'b1; addr = 4'h1; re = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
      if (n == 7) begin
        tests++;
        if (rdata_out !== 8'h00) begin fails++; $display("FAIL post_reset_early: RISE %h, required 00", rdata_out); end
      end
      if (n == 8) begin
        tests++;
        if (rdata_out !== 8'h85) begin fails++; $display("FAIL post_reset_rise: RISE %h, required 85", rdata_out); end
      end
    end
    @(negedge clk);
    re = 1'b0;
    rd(4'h3, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL post_reset_en: RISE_EN %h, required 00", d); end
    rd(4'h2, d);
    tests++;
    if (d !== 8'h00) begin fails++; $display("FAIL post_reset_fall: FALL %h, required 00", d); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      gpio_in ^= 8'($urandom & $urandom & $urandom);
      re    = 1'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      addr  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      wdata = 8'($urandom);
      @(posedge clk);
      #1;
      tests++;
      if (rdata_out !== rd_m) begin
        fails++;
        $display("FAIL rand_rdata cycle %0d: got %h, model %h", n, rdata_out, rd_m);
      end
      tests++;
      if (irq !== irq_m) begin
        fails++;
        $display("FAIL rand_irq cycle %0d: got %b, model %b", n, irq, irq_m);
      end
    end
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    test_reset;
    test_rise_latency;
    test_glitch;
    test_irq_w1c;
    test_set_beats_clear;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
